// File: rtl/demux_pkg.sv
// Shared types and elaboration helpers for the word-to-slice demux serializer.
package demux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int ratio(input int mst, input int sys);
    return mst / sys;
  endfunction

  // A one-beat word still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic bit cfg_ok(input int mst, input int sys, input int nch);
    return (sys > 0) && (mst >= sys) && ((mst % sys) == 0) && (nch >= 2);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Single-channel view of the serializer: loads a word, presents it MSB slice
// first and advances one slice per accepted beat.
module word_serializer
  import demux_pkg::*;
#(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [MST_DWIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [SYS_DWIDTH-1:0] data_o
);

  localparam int RATIO = ratio(MST_DWIDTH, SYS_DWIDTH);
  localparam int CNT_W = cnt_width(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MST_DWIDTH-1:0]   shreg_q, shreg_d;
  logic                    last_beat;

  assign last_beat = (cnt_q == LAST_BEAT);
  assign valid_o   = (state_q == SHIFT);
  assign data_o    = shreg_q[MST_DWIDTH-1 -: SYS_DWIDTH];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (load_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = data_i;
        end
      end
      SHIFT: begin
        // Taking the next word on the last beat keeps the stream bubble-free.
        ready_o = last_beat & ready_i;
        if (ready_i) begin
          if (last_beat) begin
            cnt_d = '0;
            if (load_i) shreg_d = data_i;
            else        state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = shreg_q << SYS_DWIDTH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the small shift
  // register is reset too so no stale word can leak out after reset.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/demux_serializer.sv
// Splits master-side words into slices and routes them to one of NUM_CH
// channels; words addressed to a non-existent channel are dropped and flagged.
module demux_serializer
  import demux_pkg::*;
#(
  parameter int  MST_DWIDTH = 32,
  parameter int  SYS_DWIDTH = 8,
  parameter int  NUM_CH     = 3,
  localparam int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             select_i,
  input  logic [MST_DWIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [NUM_CH*SYS_DWIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            valid_o,
  input  logic [NUM_CH-1:0]            ready_i,
  output logic                         drop_o
);

  if (!cfg_ok(MST_DWIDTH, SYS_DWIDTH, NUM_CH)) begin : g_cfg_err
    $error("demux_serializer: MST_DWIDTH must be a multiple of SYS_DWIDTH and NUM_CH >= 2");
  end

  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  drop_q, drop_d;
  logic                  accept, sel_ok, load;
  logic                  ser_ready, ser_valid, ready_sel;
  logic [SYS_DWIDTH-1:0] ser_data;

  // Widened compare so a power-of-two NUM_CH does not wrap to zero.
  assign sel_ok    = ({1'b0, select_i} < (SEL_W + 1)'(NUM_CH));
  assign ready_o   = ser_ready;
  assign accept    = valid_i & ready_o;
  assign load      = accept & sel_ok;
  assign ready_sel = ready_i[sel_q];
  assign drop_o    = drop_q;

  always_comb begin
    sel_d  = load ? select_i : sel_q;
    drop_d = accept & ~sel_ok;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      drop_q <= drop_d;
    end
  end

  word_serializer #(
    .MST_DWIDTH(MST_DWIDTH),
    .SYS_DWIDTH(SYS_DWIDTH)
  ) u_ser (
    .clk_sys(clk_sys),
    .rst    (rst),
    .load_i (load),
    .data_i (data_i),
    .ready_i(ready_sel),
    .ready_o(ser_ready),
    .valid_o(ser_valid),
    .data_o (ser_data)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign valid_o[c] = ser_valid & (sel_q == SEL_W'(c));
    assign data_o[c*SYS_DWIDTH +: SYS_DWIDTH] = valid_o[c] ? ser_data : '0;
  end

endmodule

// File: tb/tb_demux_serializer.sv
// Directed bench for demux_serializer: a slice scoreboard on the default
// configuration plus short directed runs on the 64/16/5 and 8/8/2 variants.
module tb_demux_serializer;

  logic        clk_sys = 1'b0;
  logic        rst;

  // Default configuration: 32/8/3
  logic [1:0]  select_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [23:0] data_o;
  logic [2:0]  valid_o;
  logic [2:0]  ready_i;
  logic        drop_o;

  // Wide configuration: 64/16/5
  logic [2:0]  b_sel;
  logic [63:0] b_data;
  logic        b_valid;
  logic        b_ready_o;
  logic [79:0] b_data_o;
  logic [4:0]  b_valid_o;
  logic [4:0]  b_ready_i;
  logic        b_drop;

  // Degenerate configuration: 8/8/2
  logic [0:0]  c_sel;
  logic [7:0]  c_data;
  logic        c_valid;
  logic        c_ready_o;
  logic [15:0] c_data_o;
  logic [1:0]  c_valid_o;
  logic [1:0]  c_ready_i;
  logic        c_drop;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         ch;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   drop_pending = 0;

  always #5 clk_sys = ~clk_sys;

  demux_serializer dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .select_i(select_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .drop_o  (drop_o)
  );

  demux_serializer #(.MST_DWIDTH(64), .SYS_DWIDTH(16), .NUM_CH(5)) dut_wide (
    .clk_sys (clk_sys),
    .rst     (rst),
    .select_i(b_sel),
    .data_i  (b_data),
    .valid_i (b_valid),
    .ready_o (b_ready_o),
    .data_o  (b_data_o),
    .valid_o (b_valid_o),
    .ready_i (b_ready_i),
    .drop_o  (b_drop)
  );

  demux_serializer #(.MST_DWIDTH(8), .SYS_DWIDTH(8), .NUM_CH(2)) dut_r1 (
    .clk_sys (clk_sys),
    .rst     (rst),
    .select_i(c_sel),
    .data_i  (c_data),
    .valid_i (c_valid),
    .ready_o (c_ready_o),
    .data_o  (c_data_o),
    .valid_o (c_valid_o),
    .ready_i (c_ready_i),
    .drop_o  (c_drop)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Holds valid_i until the word is accepted; reports how many cycles it took.
  task automatic send(input logic [1:0] sel, input logic [31:0] w, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    select_i = sel;
    data_i   = w;
    valid_i  = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk_sys);
      waits++;
      if (ready_o) done = 1'b1;
      tick();
    end
    check("send_accept", done, 1);
    if (done) begin
      if (sel < 2'd3) begin
        for (int k = 0; k < 4; k++) exp_q.push_back('{ch: int'(sel), d: 8'(w >> (24 - 8 * k))});
      end else begin
        drop_pending++;
      end
    end
  endtask

  // Scoreboard monitor: every slice handed over on a channel must match the queue.
  always @(negedge clk_sys) begin
    if (!rst) begin
      check("onehot_valid", $countones(valid_o) <= 1, 1);
      for (int c = 0; c < 3; c++) begin
        if (valid_o[c] && ready_i[c]) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_slice_ch", c, 64'hFF);
          end else begin
            mon_e = exp_q.pop_front();
            check("sb_chan", c, mon_e.ch);
            check("sb_data", data_o[c*8 +: 8], mon_e.d);
          end
        end else if (!valid_o[c]) begin
          check("idle_data_zero", data_o[c*8 +: 8], 0);
        end
      end
      if (drop_o) begin
        check("drop_expected", drop_pending > 0, 1);
        if (drop_pending > 0) drop_pending--;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [31:0] word;
    logic [63:0] wword;

    rst = 1'b1;
    valid_i = 1'b0; select_i = '0; data_i = '0; ready_i = 3'b111;
    b_valid = 1'b0; b_sel = '0; b_data = '0; b_ready_i = '1;
    c_valid = 1'b0; c_sel = '0; c_data = '0; c_ready_i = '1;
    repeat (3) @(posedge clk_sys);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk_sys);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_drop", drop_o, 0);
    tick();

    // Single word on channel 1
    word = 32'hA1B2C3D4;
    send(2'd1, word, w);
    valid_i = 1'b0;
    check("t2_wait", w, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      check("t2_valid", valid_o, 3'b010);
      check("t2_data", data_o[15:8], 8'(word >> (24 - 8 * k)));
      check("t2_ready", ready_o, (k == 3));
      tick();
    end
    @(negedge clk_sys);
    check("t2_done", valid_o, 0);
    tick();

    // Back-to-back words, valid held
    send(2'd0, 32'h01020304, w);
    check("t3_wait0", w, 1);
    word = 32'h05060708;
    send(2'd2, word, w);
    check("t3_wait1", w, 4);
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      check("t3_valid", valid_o, 3'b100);
      check("t3_data", data_o[23:16], 8'(word >> (24 - 8 * k)));
      tick();
    end
    @(negedge clk_sys);
    check("t3_done", valid_o, 0);
    tick();

    // Backpressure on channel 2 at beat 1
    send(2'd2, 32'hDEADBEEF, w);
    valid_i = 1'b0;
    @(negedge clk_sys);
    check("t4_beat0", data_o[23:16], 8'hDE);
    tick();
    ready_i = 3'b011;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      check("t4_hold_data", data_o[23:16], 8'hAD);
      check("t4_hold_valid", valid_o, 3'b100);
      check("t4_hold_ready", ready_o, 0);
      tick();
    end
    ready_i = 3'b111;
    @(negedge clk_sys);
    check("t4_release_data", data_o[23:16], 8'hAD);
    check("t4_release_ready", ready_o, 0);
    tick();
    @(negedge clk_sys);
    check("t4_beat2", data_o[23:16], 8'hBE);
    check("t4_beat2_ready", ready_o, 0);
    tick();
    @(negedge clk_sys);
    check("t4_beat3", data_o[23:16], 8'hEF);
    check("t4_beat3_ready", ready_o, 1);
    tick();
    @(negedge clk_sys);
    check("t4_done", valid_o, 0);
    tick();

    // Invalid select
    send(2'd3, 32'hFFFFFFFF, w);
    valid_i = 1'b0;
    @(negedge clk_sys);
    check("t5_drop", drop_o, 1);
    check("t5_valid", valid_o, 0);
    tick();
    @(negedge clk_sys);
    check("t5_drop_pulse", drop_o, 0);
    tick();

    // Zero word on channel 0
    send(2'd0, 32'h0, w);
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      check("t6_valid", valid_o, 3'b001);
      check("t6_data", data_o[7:0], 0);
      tick();
    end

    // Reset in the middle of a word
    send(2'd1, 32'h11223344, w);
    valid_i = 1'b0;
    @(negedge clk_sys);
    check("t1_pre_valid", valid_o, 3'b010);
    #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk_sys);
    check("t1_in_rst_valid", valid_o, 0);
    check("t1_in_rst_data", data_o, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      check("t1_post_valid", valid_o, 0);
      check("t1_post_ready", ready_o, 1);
      tick();
    end

    // Wide variant: 64/16/5, last channel, then an invalid select
    wword   = 64'h0123456789ABCDEF;
    b_sel   = 3'd4;
    b_data  = wword;
    b_valid = 1'b1;
    @(negedge clk_sys);
    check("w_ready", b_ready_o, 1);
    tick();
    b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      check("w_valid", b_valid_o, 5'b10000);
      check("w_data", b_data_o[79:64], 16'(wword >> (48 - 16 * k)));
      check("w_idle_data", b_data_o[63:0], 0);
      tick();
    end
    @(negedge clk_sys);
    check("w_done", b_valid_o, 0);
    tick();
    b_sel   = 3'd5;
    b_data  = '1;
    b_valid = 1'b1;
    @(negedge clk_sys);
    check("w_drop_ready", b_ready_o, 1);
    tick();
    b_valid = 1'b0;
    @(negedge clk_sys);
    check("w_drop", b_drop, 1);
    check("w_drop_valid", b_valid_o, 0);
    tick();
    @(negedge clk_sys);
    check("w_drop_pulse", b_drop, 0);
    tick();

    // Ratio-1 variant: one word per cycle, then backpressure
    c_valid = 1'b1;
    c_sel = 1'b0; c_data = 8'h5A;
    @(negedge clk_sys);
    check("r1_ready0", c_ready_o, 1);
    tick();
    c_sel = 1'b1; c_data = 8'hA5;
    @(negedge clk_sys);
    check("r1_valid0", c_valid_o, 2'b01);
    check("r1_data0", c_data_o, 16'h005A);
    check("r1_ready1", c_ready_o, 1);
    tick();
    c_sel = 1'b0; c_data = 8'h00;
    @(negedge clk_sys);
    check("r1_valid1", c_valid_o, 2'b10);
    check("r1_data1", c_data_o, 16'hA500);
    check("r1_ready2", c_ready_o, 1);
    tick();
    c_valid   = 1'b0;
    c_ready_i = 2'b10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_sys);
      check("r1_hold_valid", c_valid_o, 2'b01);
      check("r1_hold_data", c_data_o, 0);
      check("r1_hold_ready", c_ready_o, 0);
      tick();
    end
    c_ready_i = 2'b11;
    @(negedge clk_sys);
    check("r1_release_ready", c_ready_o, 1);
    tick();
    @(negedge clk_sys);
    check("r1_done", c_valid_o, 0);
    tick();

    check("sb_empty", exp_q.size(), 0);
    check("drop_all_seen", drop_pending, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
